// File: rtl/l2switch_egress_arb.sv
// Frame-granular round-robin merge of NPORT ingress queues into one egress FIFO; data is registered (1 cycle).
// Stalls on empty head or egress almost-full without bubbles; drained frames ignore out_full.
module l2switch_egress_arb #(
  parameter int NPORT     = 4,
  parameter int PORT_ID   = 0,
  parameter int MAX_WORDS = 200,
  parameter int GAP       = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NPORT*72-1:0] in_dout,
  input  logic [NPORT-1:0]    in_empty,
  output logic [NPORT-1:0]    in_rd_en,
  input  logic [NPORT-1:0]    port_en,
  output logic [71:0]         out_din,
  output logic                out_wr_en,
  input  logic                out_full,
  output logic [31:0]         tx_frames,
  output logic [31:0]         drop_frames
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [WW-1:0] MAX_W    = WW'(MAX_WORDS);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef struct packed {
    logic [7:0]  flags;
    logic [63:0] data;
  } word_t;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]   word_cnt_q, word_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            drop_pend_q, drop_pend_d;
  word_t           out_din_q, out_din_d;
  logic            out_wr_en_q, out_wr_en_d;
  logic [31:0]     tx_q, tx_d;
  logic [31:0]     drop_q, drop_d;

  word_t           lanes [NPORT];
  word_t           head;
  logic            head_vld;
  logic            is_last;
  logic            grant_vld;
  logic [PW-1:0]   grant_idx;
  logic [NPORT-1:0] rd;
  int              idx;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      lanes[i] = in_dout[72*i +: 72];
    end
  end

  assign head     = lanes[rr_ptr_q];
  assign head_vld = !in_empty[rr_ptr_q];
  assign is_last  = (head.flags != 8'hff);

  // Search starts just past the last grant, so the last winner is checked last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NPORT; k++) begin
      idx = (int'(rr_ptr_q) + k) % NPORT;
      if (!grant_vld && !in_empty[PW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    drop_pend_d = drop_pend_q;
    out_din_d   = out_din_q;
    out_wr_en_d = 1'b0;
    tx_d        = tx_q;
    drop_d      = drop_q;
    rd          = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          rr_ptr_d   = grant_idx;
          word_cnt_d = '0;
          if (port_en[grant_idx] && (grant_idx != PW'(PORT_ID))) begin
            state_d = S_XFER;
          end else begin
            state_d     = S_DRAIN;
            drop_pend_d = 1'b1;
          end
        end
      end

      S_XFER: begin
        if (head_vld && !out_full) begin
          rd[rr_ptr_q] = 1'b1;
          word_cnt_d   = word_cnt_q + WW'(1);
          out_wr_en_d  = 1'b1;
          out_din_d    = head;
          if (is_last) begin
            tx_d      = tx_q + 32'd1;
            gap_cnt_d = '0;
            state_d   = (GAP == 0) ? S_IDLE : S_GAP;
          end else if (word_cnt_d == MAX_W) begin
            // Oversize: close the egress frame with an empty terminator, discard the rest.
            out_din_d   = '0;
            drop_d      = drop_q + 32'd1;
            drop_pend_d = 1'b0;
            state_d     = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (head_vld) begin
          rd[rr_ptr_q] = 1'b1;
          if (is_last) begin
            if (drop_pend_q) begin
              drop_d = drop_q + 32'd1;
            end
            gap_cnt_d = '0;
            state_d   = (GAP == 0) ? S_IDLE : S_GAP;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= PW'(NPORT - 1);
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      drop_pend_q <= 1'b0;
      out_din_q   <= '0;
      out_wr_en_q <= 1'b0;
      tx_q        <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      drop_pend_q <= drop_pend_d;
      out_din_q   <= out_din_d;
      out_wr_en_q <= out_wr_en_d;
      tx_q        <= tx_d;
      drop_q      <= drop_d;
    end
  end

  assign in_rd_en    = sys_rst ? '0 : rd;
  assign out_din     = out_din_q;
  assign out_wr_en   = out_wr_en_q;
  assign tx_frames   = tx_q;
  assign drop_frames = drop_q;

endmodule

// File: doc/l2switch_egress_arb.md
Name: l2switch_egress_arb

Overview:
- Frame-granular, round-robin arbiter for one egress port of the N-port L2 switch. Runs in the sys_clk domain.
- Merges NPORT per-ingress virtual output queues (FIFO72 read side) into one egress FIFO72 write side, which feeds fifo72toxgmii.
- Replaces the fixed 2-port cross-connect. Adds per-port enable, hairpin suppression, an oversize-frame guard and frame/drop counters.

Parameters:
- NPORT, 4, number of ingress queues (2..8).
- PORT_ID, 0, index of this egress port. Frames queued on input PORT_ID are never forwarded.
- MAX_WORDS, 200, maximum 72-bit words per frame before the frame is treated as oversize.
- GAP, 1, idle cycles inserted after each completed frame before the next arbitration.

Ports:
- sys_clk  in  1  single clock for the whole block.
- sys_rst  in  1  reset; synchronous, active-high.
- in_dout  in  NPORT*72  queue heads; lane i is bits [72*i+71:72*i].
- in_empty  in  NPORT  queue empty flags.
- in_rd_en  out  NPORT  pop strobes, one-hot or zero.
- port_en  in  NPORT  ingress enable mask; 0 means that queue's frames are dropped.
- out_din  out  72  egress word.
- out_wr_en  out  1  egress write strobe.
- out_full  in  1  egress almost-full; asserted while fewer than 2 free entries remain.
- tx_frames  out  32  frames forwarded; wraps at 2^32.
- drop_frames  out  32  frames discarded; wraps at 2^32.

Behaviour:
- FIFO72 word format:
  - [71:64] per-lane byte-valid flags; [63:0] data, lane 0 in [7:0].
  - A word with flags == 8'hff is mid-frame.
  - Any other value is the frame's last word. 8'h00 is an empty terminator.
- Queues are first-word-fall-through: in_dout lane i is valid while in_empty[i]==0. in_rd_en[i] pops that word at the clock edge.
- Reset values: in_rd_en=0, out_wr_en=0, out_din=72'h0, tx_frames=0, drop_frames=0, state=IDLE, rr_ptr=NPORT-1, word_cnt=0, gap_cnt=0.
- IDLE:
  - Grant the first i with in_empty[i]==0, searching from rr_ptr+1 upward modulo NPORT.
  - On grant: rr_ptr<=i, word_cnt<=0. Go to XFER if port_en[i]==1 and i!=PORT_ID, otherwise DRAIN.
  - The granting cycle does not pop.
- XFER:
  - Each cycle with in_empty[g]==0 and out_full==0: assert in_rd_en[g] combinationally, and word_cnt++.
  - Registered output, latency 1 cycle: next edge out_din<=in_dout[g], out_wr_en<=1. Otherwise out_wr_en<=0.
  - Stalls (empty or full) hold state and insert no bubbles into the data.
  - Popped word has flags!=8'hff: tx_frames++ and go to GAP.
  - Popped word has flags==8'hff and word_cnt reaches MAX_WORDS:
    - write a terminator word {8'h00,64'h0} in place of the popped word;
    - drop_frames++, then go to DRAIN to discard the rest of the frame.
  - The partially sent frame is not counted in tx_frames.
- DRAIN:
  - Pop in_rd_en[g] whenever in_empty[g]==0, regardless of out_full. No egress writes.
  - On the last word: go to GAP. Increment drop_frames here only if DRAIN was entered from IDLE.
- GAP: hold for GAP cycles (gap_cnt), then go to IDLE. If GAP=0, go straight to IDLE the next cycle.
- Fairness: a port granted once is searched last next time.
- port_en changes take effect only at the next grant. A frame in progress finishes in its current mode.
- Simultaneous events:
  - The last-word pop and out_full rising in the same cycle still completes the frame, because out_full has one entry of headroom.
  - Both counters may increment in the same cycle only across different frames, which cannot happen. At most one counter increments per cycle.
- Reset mid-frame: returns to IDLE next edge with out_wr_en=0. The egress frame is left truncated, with no terminator emitted. The ingress remainder is resolved by the ingress FIFOs also being reset.

Test Plan:
- NPORT=4, PORT_ID=0, all enabled. 3-word frames queued on ports 1,2,3 simultaneously:
  - egress order is 1,2,3;
  - each frame is 3 consecutive writes with data identical to the input;
  - tx_frames=3;
  - at least GAP idle cycles between frames.
- Frame on port 0 (hairpin), 5 words: zero egress writes, all 5 words popped, drop_frames=1, tx_frames=0.
- port_en=4'b1011, frames on ports 1 and 2: port 1 forwarded; port 2 drained; tx_frames=1, drop_frames=1.
- out_full held high for 10 cycles mid-frame:
  - no pops and no writes during that window;
  - after release the frame resumes with no word lost or duplicated; final word flags=8'h0f preserved.
- MAX_WORDS=8, 12-word frame on port 1:
  - 7 data words, then a {8'h00,64'h0} terminator, are written;
  - remaining words are drained;
  - drop_frames=1, tx_frames=0, and the next frame forwards normally.
- sys_rst pulsed mid-XFER: next cycle out_wr_en=0, counters=0, state IDLE; after release, arbitration starts from port 0.
